lc3_mem_ctrl: RTL
=================

LC3_MEM_CTRL -- requirements
Module: lc3_mem_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- Buss  in  16  shared datapath bus.
- ldMAR  in  1  MAR <= Buss.
- ldMDR  in  1  load MDR.
- selMDR  in  1  MDR source: 1 = memory read, 0 = Buss.
- memWE  in  1  write MDR to M[MAR].
- mdrOut  out  16  MDR contents, to the bus tri-state driver.
- memRdy  out  1  high = controller idle; the control FSM holds its state while low.
- mem_req  out  1  external request.
- mem_we  out  1  external write strobe.
- mem_addr  out  16  external address.
- mem_wdata  out  16  external write data.
- mem_rdata  in  16  external read data.
- mem_ack  in  1  external completion, one-cycle pulse.
- kbd_data  in  8  keyboard character (MMIO build only).
- kbd_valid  in  1  keyboard character strobe (MMIO build only).
- dsp_data  out  8  display character (MMIO build only).
- dsp_valid  out  1  display character strobe (MMIO build only).
- dsp_ready  in  1  display can accept a character (MMIO build only).

Function
REQ-003 ldMAR SHALL update MAR at the clock edge in any state; in-flight mem_addr is unaffected.
REQ-004 ldMDR with selMDR=0 in IDLE SHALL load MDR from Buss in one cycle.
REQ-005 The state machine SHALL have states IDLE, RD_WAIT and WR_WAIT.
REQ-006 IDLE transitions:
- ldMDR & selMDR -> RD_WAIT.
- memWE -> WR_WAIT.
- mem_addr and mem_wdata SHALL be registered from MAR and MDR at that edge.
REQ-007 If memWE and ldMDR&selMDR are asserted in the same cycle, the write SHALL win and the read SHALL be dropped.
REQ-008 mem_req SHALL be high throughout RD_WAIT and WR_WAIT; mem_we SHALL be high only in WR_WAIT; mem_addr and mem_wdata SHALL be stable until ack.
REQ-009 RD_WAIT with mem_ack SHALL load MDR from mem_rdata and move to IDLE. WR_WAIT with mem_ack SHALL move to IDLE.
REQ-010 memRdy SHALL equal (state==IDLE) & ~(read or write start this cycle), combinationally.
REQ-011 Minimum memory access latency: start cycle plus one wait cycle; memRdy SHALL rise the cycle after mem_ack.
REQ-012 ldMDR and memWE SHALL be ignored outside IDLE; mem_ack in IDLE SHALL be ignored.
REQ-013 mdrOut SHALL be driven from the MDR register directly, with no combinational path from mem_rdata.

Reset
REQ-014 reset low SHALL asynchronously force:
- state to IDLE.
- MAR, MDR, mem_addr and mem_wdata to 0.
- mem_req, mem_we and dsp_valid to 0.
- KBSR[15] to 0.
REQ-015 A reset asserted mid-transaction SHALL abort it; a mem_ack arriving after reset is released SHALL be ignored.

Configuration
REQ-016 With LC3_MMIO_EN defined, the block SHALL decode these addresses locally, complete the access the cycle after start with no mem_req, and include the kbd_*/dsp_* ports:
- xFE00 KBSR: bit15 = keyboard full.
- xFE02 KBDR: read returns {8'h00, char} and clears full.
- xFE04 DSR: bit15 = dsp_ready.
- xFE06 DDR: write pulses dsp_valid for one cycle with dsp_data = MDR[7:0].
REQ-017 A kbd_valid pulse SHALL latch kbd_data and set KBSR[15]; if it coincides with a KBDR read, the set SHALL win.
REQ-018 Without LC3_MMIO_EN, every address SHALL go to external memory and the kbd_*/dsp_* ports SHALL be absent.

Structure
REQ-019 Package lc3_pkg SHALL hold the state enum, the MMIO address constants and the 16-bit word typedef.
REQ-020 The MMIO registers SHALL live in one sub-module, lc3_mmio, instantiated only under LC3_MMIO_EN.

Verification
REQ-021 Read: MAR=x3000, read start, mem_ack after 3 waits with mem_rdata=x1234 -> MDR=x1234; memRdy low for 4 cycles.
REQ-022 Write: MAR=x4000, MDR=xBEEF, memWE -> mem_we=1, addr=x4000, wdata=xBEEF held until ack.
REQ-023 Simultaneous memWE and read start -> WR_WAIT entered, no read; ldMAR=x5555 during the wait leaves mem_addr unchanged.
REQ-024 reset low during RD_WAIT -> mem_req low immediately, MDR=0, state IDLE; a later ack changes nothing.
REQ-025 LC3_MMIO_EN: kbd_valid with x41, then read xFE00 -> x8000; read xFE02 -> x0041; read xFE00 -> x0000; write xFE06 -> dsp_valid for one cycle; no mem_req at any point.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC-3 memory controller.
// MMIO register addresses are only decoded when LC3_MMIO_EN is defined.
package lc3_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } memState_t;

    localparam word_t KBSR_ADDR = 16'hFE00;
    localparam word_t KBDR_ADDR = 16'hFE02;
    localparam word_t DSR_ADDR  = 16'hFE04;
    localparam word_t DDR_ADDR  = 16'hFE06;

    function automatic logic isMmioAddr(input word_t addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_mmio.sv
// Keyboard and display device registers, decoded locally by the memory controller.
// Only instantiated in builds with LC3_MMIO_EN defined.
module lc3_mmio
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  word_t       addr,
    input  logic        rdDone,
    input  logic        wrDone,
    input  logic [7:0]  wdata,
    output word_t       rdata,
    input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic [7:0]  dsp_data,
    output logic        dsp_valid,
    input  logic        dsp_ready
);

    logic       kbdFull;
    logic [7:0] kbdChar;

    // A new keystroke takes priority over the KBDR read that would clear the full flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kbdFull   <= 1'b0;
            kbdChar   <= 8'h00;
            dsp_valid <= 1'b0;
            dsp_data  <= 8'h00;
        end else begin
            dsp_valid <= 1'b0;
            if (kbd_valid) begin
                kbdChar <= kbd_data;
                kbdFull <= 1'b1;
            end else if (rdDone && addr == KBDR_ADDR) begin
                kbdFull <= 1'b0;
            end
            if (wrDone && addr == DDR_ADDR) begin
                dsp_valid <= 1'b1;
                dsp_data  <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            KBSR_ADDR: rdata = {kbdFull, 15'b0};
            KBDR_ADDR: rdata = {8'h00, kbdChar};
            DSR_ADDR:  rdata = {dsp_ready, 15'b0};
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 MAR/MDR memory controller with an external request/ack memory port.
// Define LC3_MMIO_EN to decode the keyboard/display registers locally.
module lc3_mem_ctrl
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Buss,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        selMDR,
    input  logic        memWE,
    output logic [15:0] mdrOut,
    output logic        memRdy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
`ifdef LC3_MMIO_EN
   ,input  logic [7:0]  kbd_data,
    input  logic        kbd_valid,
    output logic [7:0]  dsp_data,
    output logic        dsp_valid,
    input  logic        dsp_ready
`endif
);

    memState_t state, nextState;
    word_t     mar, mdr, memAddr, memWdata, rdData;
    logic      idle, readStart, writeStart, done;

    assign idle       = (state == IDLE);
    assign writeStart = idle & memWE;
    assign readStart  = idle & ldMDR & selMDR & ~memWE;
    assign memRdy     = idle & ~(readStart | writeStart);
    assign mdrOut     = mdr;
    assign mem_addr   = memAddr;
    assign mem_wdata  = memWdata;

`ifdef LC3_MMIO_EN
    logic  localAcc;
    word_t mmioRdata;
    logic  mmioRdDone, mmioWrDone;

    // Local accesses finish in the first wait cycle and never reach the external port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            localAcc <= 1'b0;
        else if (readStart | writeStart)
            localAcc <= isMmioAddr(mar);
    end

    assign mmioRdDone = (state == RD_WAIT) & localAcc;
    assign mmioWrDone = (state == WR_WAIT) & localAcc;
    assign done       = localAcc | mem_ack;
    assign rdData     = localAcc ? mmioRdata : mem_rdata;
    assign mem_req    = ((state == RD_WAIT) | (state == WR_WAIT)) & ~localAcc;
    assign mem_we     = (state == WR_WAIT) & ~localAcc;

    lc3_mmio u_mmio (
        .clk       (clk),
        .reset     (reset),
        .addr      (memAddr),
        .rdDone    (mmioRdDone),
        .wrDone    (mmioWrDone),
        .wdata     (memWdata[7:0]),
        .rdata     (mmioRdata),
        .kbd_data  (kbd_data),
        .kbd_valid (kbd_valid),
        .dsp_data  (dsp_data),
        .dsp_valid (dsp_valid),
        .dsp_ready (dsp_ready)
    );
`else
    assign done    = mem_ack;
    assign rdData  = mem_rdata;
    assign mem_req = (state == RD_WAIT) | (state == WR_WAIT);
    assign mem_we  = (state == WR_WAIT);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (writeStart)
                    nextState = WR_WAIT;
                else if (readStart)
                    nextState = RD_WAIT;
            end
            RD_WAIT: if (done) nextState = IDLE;
            WR_WAIT: if (done) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The address/data snapshot at start keeps the external port stable while MAR moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mar      <= '0;
            mdr      <= '0;
            memAddr  <= '0;
            memWdata <= '0;
        end else begin
            if (ldMAR)
                mar <= Buss;
            if (readStart | writeStart) begin
                memAddr  <= mar;
                memWdata <= mdr;
            end
            if (idle & ldMDR & ~selMDR)
                mdr <= Buss;
            else if ((state == RD_WAIT) & done)
                mdr <= rdData;
        end
    end

endmodule
